// File: rtl/conv_acc_multi.sv
// conv_acc_multi: multi-output windowed convolution accumulator.
// Five-stage pipeline: S1 input register, S2 products, S3 channel sums,
// S4 saturating accumulate, S5 bias/shift/saturate into q.
// Optional feature macro: CONV_ACC_RELU_EN (clamps negative results to 0).
// Data width macros `WD / `WD_BIAS default to 16 when not provided.

`ifndef WD
`define WD 16
`endif
`ifndef WD_BIAS
`define WD_BIAS 16
`endif

module conv_acc_multi #(
    parameter int INPUT_NUM  = 3,
    parameter int OUTPUT_NUM = 6,
    parameter int SHIFT      = 15,
    parameter int ACC_W      = 2*`WD+8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_en,
    input  logic                                  in_first,
    input  logic                                  in_last,
    input  logic [`WD*INPUT_NUM-1:0]              image,
    input  logic [`WD*INPUT_NUM*OUTPUT_NUM-1:0]   weight,
    input  logic [`WD_BIAS*OUTPUT_NUM-1:0]        bias,
    output logic [`WD*OUTPUT_NUM-1:0]             q,
    output logic                                  q_en,
    output logic [OUTPUT_NUM-1:0]                 q_sat,
    output logic                                  seq_err
);

    localparam int WD     = `WD;
    localparam int WB     = `WD_BIAS;
    localparam int PROD_W = 2*WD;
    localparam int SUM_W  = PROD_W + $clog2(INPUT_NUM+1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Saturating add of a channel sum into the accumulator; returns {overflow, value}.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [SUM_W-1:0] b);
        logic signed [ACC_W:0] s;
        s = (ACC_W+1)'(a) + (ACC_W+1)'(b);
        if (s[ACC_W] != s[ACC_W-1]) begin
            if (s[ACC_W]) begin
                return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            return {1'b0, s[ACC_W-1:0]};
        end
    endfunction

    // Clamp a wide signed value into WD bits; returns {clamped, value}.
    function automatic logic [WD:0] sat_out(input logic signed [ACC_W:0] v);
        logic [ACC_W-WD+1:0] upper;
        upper = v[ACC_W:WD-1];
        if ((&upper) || (~|upper)) begin
            return {1'b0, v[WD-1:0]};
        end else if (v[ACC_W]) begin
            return {1'b1, 1'b1, {(WD-1){1'b0}}};
        end else begin
            return {1'b1, 1'b0, {(WD-1){1'b1}}};
        end
    endfunction

    state_t state_r, state_nxt_s;
    logic   accept_s, load_s, emit_s, err_s;

    logic                          v1_r, load1_r, emit1_r;
    logic                          v2_r, load2_r, emit2_r;
    logic                          v3_r, load3_r, emit3_r;
    logic                          emit4_r;
    logic [WD*INPUT_NUM-1:0]       image_r;
    logic [WD*INPUT_NUM*OUTPUT_NUM-1:0] weight_r;
    logic [WB*OUTPUT_NUM-1:0]      bias1_r, bias2_r, bias3_r, bias4_r;

    logic signed [WD-1:0]          pix_s  [INPUT_NUM];
    logic signed [WD-1:0]          wgt_s  [OUTPUT_NUM][INPUT_NUM];
    logic signed [PROD_W-1:0]      prod_r [OUTPUT_NUM][INPUT_NUM];
    logic signed [SUM_W-1:0]       sum_s  [OUTPUT_NUM];
    logic signed [SUM_W-1:0]       sum_r  [OUTPUT_NUM];
    logic signed [ACC_W-1:0]       acc_r  [OUTPUT_NUM];
    logic [ACC_W:0]                add_s  [OUTPUT_NUM];
    logic [OUTPUT_NUM-1:0]         sticky_r;
    logic [WD*OUTPUT_NUM-1:0]      q_nxt_s;
    logic [OUTPUT_NUM-1:0]         q_sat_nxt_s;

    // Framing decisions for the word presented this cycle.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        load_s      = 1'b0;
        emit_s      = 1'b0;
        err_s       = 1'b0;
        if (in_en) begin
            case (state_r)
                IDLE: begin
                    if (in_first) begin
                        accept_s = 1'b1;
                        load_s   = 1'b1;
                        if (in_last) begin
                            emit_s = 1'b1;
                        end else begin
                            state_nxt_s = ACCUM;
                        end
                    end else begin
                        err_s = 1'b1;
                    end
                end
                ACCUM: begin
                    accept_s = 1'b1;
                    if (in_first) begin
                        // Restart: abandon the open window, this word begins a new one.
                        load_s = 1'b1;
                        err_s  = 1'b1;
                    end else begin
                        load_s = 1'b0;
                    end
                    if (in_last) begin
                        emit_s      = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = ACCUM;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Framing state register and registered framing-error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            seq_err <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            seq_err <= err_s;
        end
    end

    // S1: capture accepted input words and their window control.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r     <= 1'b0;
            load1_r  <= 1'b0;
            emit1_r  <= 1'b0;
            image_r  <= '0;
            weight_r <= '0;
            bias1_r  <= '0;
        end else begin
            v1_r    <= accept_s;
            load1_r <= load_s;
            emit1_r <= emit_s;
            bias1_r <= bias;
            if (accept_s) begin
                image_r  <= image;
                weight_r <= weight;
            end else begin
                image_r  <= image_r;
                weight_r <= weight_r;
            end
        end
    end

    // Slice the registered buses into signed per-channel operands.
    always_comb begin
        for (int c = 0; c < INPUT_NUM; c++) begin
            pix_s[c] = image_r[c*WD +: WD];
        end
        for (int o = 0; o < OUTPUT_NUM; o++) begin
            for (int c = 0; c < INPUT_NUM; c++) begin
                wgt_s[o][c] = weight_r[(o*INPUT_NUM+c)*WD +: WD];
            end
        end
    end

    // S2: full-precision signed products per output/channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r    <= 1'b0;
            load2_r <= 1'b0;
            emit2_r <= 1'b0;
            bias2_r <= '0;
            for (int o = 0; o < OUTPUT_NUM; o++) begin
                for (int c = 0; c < INPUT_NUM; c++) begin
                    prod_r[o][c] <= '0;
                end
            end
        end else begin
            v2_r    <= v1_r;
            load2_r <= load1_r;
            emit2_r <= emit1_r;
            bias2_r <= bias1_r;
            for (int o = 0; o < OUTPUT_NUM; o++) begin
                for (int c = 0; c < INPUT_NUM; c++) begin
                    prod_r[o][c] <= PROD_W'(pix_s[c]) * PROD_W'(wgt_s[o][c]);
                end
            end
        end
    end

    // Lossless channel sum per output, sized to hold INPUT_NUM products.
    always_comb begin
        for (int o = 0; o < OUTPUT_NUM; o++) begin
            sum_s[o] = '0;
            for (int c = 0; c < INPUT_NUM; c++) begin
                sum_s[o] = sum_s[o] + SUM_W'(prod_r[o][c]);
            end
        end
    end

    // S3: register channel sums.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_r    <= 1'b0;
            load3_r <= 1'b0;
            emit3_r <= 1'b0;
            bias3_r <= '0;
            for (int o = 0; o < OUTPUT_NUM; o++) begin
                sum_r[o] <= '0;
            end
        end else begin
            v3_r    <= v2_r;
            load3_r <= load2_r;
            emit3_r <= emit2_r;
            bias3_r <= bias2_r;
            for (int o = 0; o < OUTPUT_NUM; o++) begin
                sum_r[o] <= sum_s[o];
            end
        end
    end

    // Saturating accumulator candidates.
    always_comb begin
        for (int o = 0; o < OUTPUT_NUM; o++) begin
            add_s[o] = sat_add(acc_r[o], sum_r[o]);
        end
    end

    // S4: load on window-first, otherwise saturating accumulate with sticky flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            emit4_r  <= 1'b0;
            bias4_r  <= '0;
            sticky_r <= '0;
            for (int o = 0; o < OUTPUT_NUM; o++) begin
                acc_r[o] <= '0;
            end
        end else begin
            emit4_r <= v3_r && emit3_r;
            bias4_r <= bias3_r;
            for (int o = 0; o < OUTPUT_NUM; o++) begin
                if (v3_r && load3_r) begin
                    acc_r[o]    <= ACC_W'(sum_r[o]);
                    sticky_r[o] <= 1'b0;
                end else if (v3_r) begin
                    acc_r[o]    <= add_s[o][ACC_W-1:0];
                    sticky_r[o] <= sticky_r[o] | add_s[o][ACC_W];
                end else begin
                    acc_r[o]    <= acc_r[o];
                    sticky_r[o] <= sticky_r[o];
                end
            end
        end
    end

    // Bias add at ACC_W+1 bits, arithmetic shift, clamp, optional ReLU.
    always_comb begin
        logic signed [ACC_W:0] wide_v;
        logic signed [ACC_W:0] shr_v;
        logic [WD:0]           out_v;
        q_nxt_s     = '0;
        q_sat_nxt_s = '0;
        wide_v      = '0;
        shr_v       = '0;
        out_v       = '0;
        for (int o = 0; o < OUTPUT_NUM; o++) begin
            wide_v = (ACC_W+1)'(acc_r[o]) + (ACC_W+1)'($signed(bias4_r[o*WB +: WB]));
            shr_v  = wide_v >>> SHIFT;
            out_v  = sat_out(shr_v);
            q_sat_nxt_s[o] = sticky_r[o] | out_v[WD];
`ifdef CONV_ACC_RELU_EN
            if (out_v[WD-1]) begin
                q_nxt_s[o*WD +: WD] = '0;
            end else begin
                q_nxt_s[o*WD +: WD] = out_v[WD-1:0];
            end
`else
            q_nxt_s[o*WD +: WD] = out_v[WD-1:0];
`endif
        end
    end

    // S5: register results on window completion, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            q_en  <= 1'b0;
            q_sat <= '0;
        end else begin
            q_en <= emit4_r;
            if (emit4_r) begin
                q     <= q_nxt_s;
                q_sat <= q_sat_nxt_s;
            end else begin
                q     <= q;
                q_sat <= q_sat;
            end
        end
    end

endmodule

// File: tb/tb_conv_acc_multi.sv
// Self-checking bench for conv_acc_multi: directed spec vectors plus random
// windows, checked against a window-level arithmetic reference model.
// Two instances run in lockstep: SHIFT=0 and SHIFT=15.

module tb_conv_acc_multi;

    localparam int WD   = 16;
    localparam int IN_N = 3;
    localparam int OUT_N = 6;
    localparam int SH1  = 15;

    logic clk = 1'b0;
    logic rst, in_en, in_first, in_last;
    logic [WD*IN_N-1:0]       image;
    logic [WD*IN_N*OUT_N-1:0] weight;
    logic [WD*OUT_N-1:0]      bias;
    logic [WD*OUT_N-1:0]      q0, q1;
    logic                     q_en0, q_en1, seq_err0, seq_err1;
    logic [OUT_N-1:0]         q_sat0, q_sat1;

    conv_acc_multi #(.INPUT_NUM(IN_N), .OUTPUT_NUM(OUT_N), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .in_en(in_en), .in_first(in_first), .in_last(in_last),
        .image(image), .weight(weight), .bias(bias),
        .q(q0), .q_en(q_en0), .q_sat(q_sat0), .seq_err(seq_err0));

    conv_acc_multi #(.INPUT_NUM(IN_N), .OUTPUT_NUM(OUT_N), .SHIFT(SH1)) dut1 (
        .clk(clk), .rst(rst), .in_en(in_en), .in_first(in_first), .in_last(in_last),
        .image(image), .weight(weight), .bias(bias),
        .q(q1), .q_en(q_en1), .q_sat(q_sat1), .seq_err(seq_err1));

    always #5 clk = ~clk;

    typedef struct packed {
        int                 due;
        logic [WD*OUT_N-1:0] q0;
        logic [WD*OUT_N-1:0] q1;
        logic [OUT_N-1:0]    s0;
        logic [OUT_N-1:0]    s1;
    } evt_t;

    int      checks = 0;
    int      errors = 0;
    int      cyc    = 0;
    shortint img_v [IN_N];
    shortint wgt_v [OUT_N][IN_N];
    shortint bias_v[OUT_N];
    longint  m_acc [OUT_N];
    bit      m_sticky[OUT_N];
    bit      m_in_win = 1'b0;
    bit      err_now;
    evt_t    evq[$];
    logic [WD*OUT_N-1:0] exp_q0 = '0, exp_q1 = '0;
    logic [2:0] pend0 = '0, pend1 = '0;

    localparam longint ACC_MAX = (longint'(1) <<< 39) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< 39);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result of a finished window for a given shift amount.
    task automatic model_result(input int sh, output logic [WD*OUT_N-1:0] qv, output logic [OUT_N-1:0] sv);
        longint v;
        bit cl;
        qv = '0;
        sv = '0;
        for (int o = 0; o < OUT_N; o++) begin
            v  = (m_acc[o] + longint'(bias_v[o])) >>> sh;
            cl = 1'b0;
            if (v > 32767) begin v = 32767; cl = 1'b1; end
            else if (v < -32768) begin v = -32768; cl = 1'b1; end
`ifdef CONV_ACC_RELU_EN
            if (v < 0) v = 0;
`endif
            qv[o*WD +: WD] = 16'(v);
            sv[o] = cl | m_sticky[o];
        end
    endtask

    // Window-level behaviour for one sampled word.
    task automatic model_word(input bit en, input bit f, input bit l);
        longint s;
        evt_t e;
        if (en) begin
            if (!m_in_win && !f) begin
                err_now = 1'b1;
            end else begin
                if (m_in_win && f) err_now = 1'b1;
                for (int o = 0; o < OUT_N; o++) begin
                    s = 0;
                    for (int c = 0; c < IN_N; c++) s += longint'(img_v[c]) * longint'(wgt_v[o][c]);
                    if (f) begin
                        m_acc[o] = s;
                        m_sticky[o] = 1'b0;
                    end else begin
                        m_acc[o] += s;
                        if (m_acc[o] > ACC_MAX) begin m_acc[o] = ACC_MAX; m_sticky[o] = 1'b1; end
                        if (m_acc[o] < ACC_MIN) begin m_acc[o] = ACC_MIN; m_sticky[o] = 1'b1; end
                    end
                end
                if (l) begin
                    m_in_win = 1'b0;
                    e.due = cyc + 4;
                    model_result(0, e.q0, e.s0);
                    model_result(SH1, e.q1, e.s1);
                    evq.push_back(e);
                end else begin
                    m_in_win = 1'b1;
                end
            end
        end
    endtask

    // seq_err must pulse within 2 cycles of each framing violation.
    task automatic err_chk(input string tag, input logic se, input logic [2:0] p_in, output logic [2:0] p_out);
        logic [2:0] p;
        p = p_in;
        if (p[2]) begin
            chk(tag, se, 1'b1);
            p[2] = 1'b0;
        end else if (p == 3'b000) begin
            chk(tag, se, 1'b0);
        end else if (se) begin
            if (p[1]) p[1] = 1'b0;
            else p[0] = 1'b0;
        end
        p_out = p;
    endtask

    // Drive one cycle, advance the model at the sampling edge, check #1 later.
    task automatic tick(input bit r, input bit en, input bit f, input bit l);
        bit exp_qen;
        evt_t e;
        rst = r; in_en = en; in_first = f; in_last = l;
        for (int c = 0; c < IN_N; c++) image[c*WD +: WD] = img_v[c];
        for (int o = 0; o < OUT_N; o++) begin
            bias[o*WD +: WD] = bias_v[o];
            for (int c = 0; c < IN_N; c++) weight[(o*IN_N+c)*WD +: WD] = wgt_v[o][c];
        end
        @(posedge clk);
        cyc++;
        err_now = 1'b0;
        if (r) begin
            m_in_win = 1'b0;
            evq.delete();
            exp_q0 = '0;
            exp_q1 = '0;
        end else begin
            model_word(en, f, l);
        end
        pend0 = r ? 3'b000 : {pend0[1:0], err_now};
        pend1 = r ? 3'b000 : {pend1[1:0], err_now};
        #1;
        exp_qen = (evq.size() > 0) && (evq[0].due == cyc);
        if (exp_qen) begin
            e = evq.pop_front();
            exp_q0 = e.q0;
            exp_q1 = e.q1;
            chk("q_sat0", q_sat0, e.s0);
            chk("q_sat1", q_sat1, e.s1);
        end
        chk("q_en0", q_en0, exp_qen);
        chk("q_en1", q_en1, exp_qen);
        chk("q0", q0, exp_q0);
        chk("q1", q1, exp_q1);
        err_chk("seq_err0", seq_err0, pend0, pend0);
        err_chk("seq_err1", seq_err1, pend1, pend1);
    endtask

    task automatic set_uniform(input shortint i0, input shortint i1, input shortint i2,
                               input shortint w0, input shortint w1, input shortint w2,
                               input shortint b);
        img_v[0] = i0; img_v[1] = i1; img_v[2] = i2;
        for (int o = 0; o < OUT_N; o++) begin
            wgt_v[o][0] = w0; wgt_v[o][1] = w1; wgt_v[o][2] = w2;
            bias_v[o] = b;
        end
    endtask

    task automatic set_random();
        for (int c = 0; c < IN_N; c++) img_v[c] = shortint'($urandom);
        for (int o = 0; o < OUT_N; o++) begin
            bias_v[o] = shortint'($urandom);
            for (int c = 0; c < IN_N; c++) wgt_v[o][c] = shortint'($urandom);
        end
    endtask

    initial begin
        logic [WD-1:0] neg_exp;
        set_uniform(16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // One-word window: 1*4+2*5+3*6 = 32.
        set_uniform(16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd0);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("one_word_q_en", q_en0, 1'b1);
        chk("one_word_q", q0[15:0], 16'd32);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("q_held", q0[95:80], 16'd32);

        // Three words with gaps, product-sum 10 each, bias 5 -> 35.
        set_uniform(16'sd1, 16'sd1, 16'sd1, 16'sd2, 16'sd3, 16'sd5, 16'sd5);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("gap_window_q", q0[15:0], 16'd35);

        // Positive overflow clamps to 0x7FFF with q_sat.
        set_uniform(16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sd0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pos_sat_q", q0[15:0], 16'h7FFF);
        chk("pos_sat_flag", q_sat0, 6'h3F);

        // Negative mirror, back-to-back with a following window.
`ifdef CONV_ACC_RELU_EN
        neg_exp = 16'h0000;
`else
        neg_exp = 16'h8000;
`endif
        set_uniform(16'sh7FFF, 16'sh7FFF, 16'sh7FFF, -16'sh7FFF, -16'sh7FFF, -16'sh7FFF, 16'sd0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        set_uniform(16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd1);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("neg_sat_q", q0[15:0], neg_exp);
        chk("neg_sat_flag", q_sat0, 6'h3F);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b_q", q0[15:0], 16'd33);

        // Word without first while idle is discarded.
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Restart mid-window: first window abandoned, second is 32+32.
        set_uniform(16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        set_uniform(16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart_q", q0[15:0], 16'd64);

        // Reset two cycles before in_last: nothing emitted.
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (5) tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_q_cleared", q0[15:0], 16'd0);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_q", q0[15:0], 16'd32);

        // Long window driving the accumulator into saturation.
        set_uniform(16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sd0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (180) tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (5) tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Random framing and data.
        for (int i = 0; i < 600; i++) begin
            set_random();
            tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
        repeat (6) tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("drained", evq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_acc_multi.md
CONV_ACC_MULTI -- requirements
Module: conv_acc_multi

Interface
REQ-001 Parameter INPUT_NUM, default 3, input channels summed per output.
REQ-002 Parameter OUTPUT_NUM, default 6, parallel output channels.
REQ-003 Parameter SHIFT, default 15, arithmetic right shift applied after bias add.
REQ-004 Parameter ACC_W, default 2*`WD+8, signed accumulator width.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_en  in  1  input word valid.
REQ-008 in_first  in  1  first word of accumulation window; qualified by in_en.
REQ-009 in_last  in  1  last word of window; qualified by in_en.
REQ-010 image  in  `WD*INPUT_NUM  signed pixels, channel c at [`WD*(c+1)-1:`WD*c].
REQ-011 weight  in  `WD*INPUT_NUM*OUTPUT_NUM  signed weights, output o / channel c at slice index o*INPUT_NUM+c.
REQ-012 bias  in  `WD_BIAS*OUTPUT_NUM  signed bias per output.
REQ-013 q  out  `WD*OUTPUT_NUM  signed results, output o at [`WD*(o+1)-1:`WD*o].
REQ-014 q_en  out  1  one-cycle strobe, q valid.
REQ-015 q_sat  out  OUTPUT_NUM  per-output flag, valid with q_en: result or accumulator saturated.
REQ-016 seq_err  out  1  one-cycle pulse on framing violation.

Function
REQ-017 Pipeline: S1 register inputs; S2 per-output/channel signed products (2*`WD bits); S3 per-output sum over INPUT_NUM products (sign-extended, no loss); S4 accumulate; S5 bias, shift, saturate, register q.
REQ-018 Latency: q_en SHALL assert exactly 4 cycles after the edge sampling in_en&&in_last, for one cycle.
REQ-019 Framing FSM per window: IDLE -> ACCUM on in_en&&in_first&&!in_last; ACCUM -> IDLE on in_en&&in_last; in_en&&in_first&&in_last in IDLE is a one-word window, stays IDLE.
REQ-020 On window-first word accumulator SHALL load the S3 sum; on other words add S3 sum to accumulator.
REQ-021 Accumulation SHALL saturate at signed ACC_W bounds, setting an internal sticky flag cleared on window-first.
REQ-022 Output value = saturate_to_`WD((acc + sign_extend(bias)) >>> SHIFT), arithmetic shift, bias added at ACC_W+1 bits.
REQ-023 q_sat[o] = sticky accumulator flag OR output clamp for output o.
REQ-024 q SHALL hold its last value between q_en strobes.
REQ-025 in_en low cycles SHALL be bubbles: no accumulation, FSM unchanged, window may span gaps.
REQ-026 in_en without in_first in IDLE: word discarded, seq_err pulses (same 4-cycle alignment as q_en not required; pulse within 2 cycles).
REQ-027 in_first in ACCUM: current window abandoned without q_en, new window starts with this word, seq_err pulses.
REQ-028 Back-to-back windows (last then first on next cycle) SHALL produce correct independent results with no stall.
REQ-029 in_first/in_last ignored when in_en is low.

Reset
REQ-030 rst SHALL clear all pipeline valid bits, FSM to IDLE, accumulators and sticky flags to 0, q to 0, q_en/q_sat/seq_err to 0 at the next edge.
REQ-031 rst mid-window SHALL discard in-flight data; no q_en for any word sampled before or during rst.

Configuration
REQ-032 Macro CONV_ACC_RELU_EN: when defined, negative results SHALL be output as 0 after saturation (q_sat unaffected); when undefined, signed result passed unchanged.

Verification
REQ-033 INPUT_NUM=3, SHIFT=0, bias 0, image {1,2,3}, weights {4,5,6}, one-word window -> q_en 4 cycles later, q=32 all outputs.
REQ-034 Three-word window with in_en gaps, each word product-sum 10, bias 5, SHIFT=0 -> single q_en, q=35.
REQ-035 Product-sum 0x7FFF*0x7FFF*3 for 4 words, SHIFT=0 -> q=0x7FFF, q_sat set; negative mirror -> q=0x8000 (0 with CONV_ACC_RELU_EN).
REQ-036 in_first mid-window -> seq_err pulse, first window never emitted, second window correct.
REQ-037 rst asserted for one cycle two cycles before in_last -> no q_en; next clean window correct.
